// File: rtl/clock_pkg.sv
// Shared types and constants for the clock set-mode sequencer: FSM encoding,
// field indices, button slot indices and default timing parameters.
package clock_pkg;

   typedef enum logic [2:0] {
      ST_RUN,
      ST_SET_HT,
      ST_SET_HU,
      ST_SET_MT,
      ST_SET_MU
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_PLUS,
      OWN_MINUS
   } owner_t;

   localparam logic [1:0] FIELD_HT = 2'd3;
   localparam logic [1:0] FIELD_HU = 2'd2;
   localparam logic [1:0] FIELD_MT = 2'd1;
   localparam logic [1:0] FIELD_MU = 2'd0;

   localparam int NUM_BTN   = 3;
   localparam int BTN_MODE  = 2;
   localparam int BTN_PLUS  = 1;
   localparam int BTN_MINUS = 0;

   localparam int DEF_DEBOUNCE_CYCLES    = 16;
   localparam int DEF_REPEAT_DELAY_TICKS = 2;
   localparam int DEF_REPEAT_RATE_TICKS  = 1;
   localparam int DEF_TIMEOUT_TICKS      = 40;

   // RUN reports field 0, matching the idle value of setField.
   function automatic logic [1:0] field_of(input state_t s);
      case (s)
         ST_SET_HT: return FIELD_HT;
         ST_SET_HU: return FIELD_HU;
         ST_SET_MT: return FIELD_MT;
         default:   return FIELD_MU;
      endcase
   endfunction

   function automatic state_t next_mode(input state_t s);
      case (s)
         ST_RUN:    return ST_SET_HT;
         ST_SET_HT: return ST_SET_HU;
         ST_SET_HU: return ST_SET_MT;
         ST_SET_MT: return ST_SET_MU;
         default:   return ST_RUN;
      endcase
   endfunction

   function automatic logic [3:0] field_mask(input logic [1:0] f);
      return 4'b0001 << f;
   endfunction

endpackage

// File: rtl/clock_set_controller_if.sv
// Button/strobe bundle between the board buttons, the set-mode controller and
// the digit-counter chain.
interface clock_set_if;
   logic       tick;
   logic       modeBtn;
   logic       plusBtn;
   logic       minusBtn;
   logic       stopSignal;
   logic [3:0] plusOut;
   logic [3:0] minusOut;
   logic [3:0] blinkMask;
   logic [1:0] setField;

   modport master (
      output tick, modeBtn, plusBtn, minusBtn,
      input  stopSignal, plusOut, minusOut, blinkMask, setField
   );

   modport slave (
      input  tick, modeBtn, plusBtn, minusBtn,
      output stopSignal, plusOut, minusOut, blinkMask, setField
   );
endinterface

// File: rtl/button_debouncer.sv
// Two-flop synchronizer plus stable-count debouncer for one active-low button;
// press/rel pulse during the cycle whose closing edge updates the level.
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic MCLK,
   input  logic resetSignal,
   input  logic btn,
   output logic level,
   output logic press,
   output logic rel
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync1, sync2;
   logic [CW-1:0] cnt;
   logic          settle;

   assign settle = (sync2 != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
   assign press  = settle && !sync2;
   assign rel    = settle && sync2;

   always_ff @(negedge MCLK or negedge resetSignal) begin
      if (!resetSignal) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         level <= 1'b1;
         cnt   <= '0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (settle) begin
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/clock_set_controller.sv
// Set-mode sequencer: walks the four editable fields on mode presses and
// routes single/auto-repeat plus/minus strobes to the selected digit counter.
module clock_set_controller
   import clock_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES    = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY_TICKS = DEF_REPEAT_DELAY_TICKS,
   parameter int REPEAT_RATE_TICKS  = DEF_REPEAT_RATE_TICKS,
   parameter int TIMEOUT_TICKS      = DEF_TIMEOUT_TICKS
) (
   input logic        MCLK,
   input logic        resetSignal,
   clock_set_if.slave bus
);
   localparam int RPT_MAX = (REPEAT_DELAY_TICKS > REPEAT_RATE_TICKS) ?
                            REPEAT_DELAY_TICKS : REPEAT_RATE_TICKS;
   localparam int RW = $clog2(RPT_MAX + 1);
   localparam int TW = $clog2(TIMEOUT_TICKS + 1);

   logic [NUM_BTN-1:0] raw, lvl, prs, rel;
   logic               unused_mode_rel;

   assign raw = {bus.modeBtn, bus.plusBtn, bus.minusBtn};
   assign unused_mode_rel = rel[BTN_MODE];

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
      button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
         .MCLK        (MCLK),
         .resetSignal (resetSignal),
         .btn         (raw[g]),
         .level       (lvl[g]),
         .press       (prs[g]),
         .rel         (rel[g])
      );
   end

   state_t        state_q, state_d;
   owner_t        own_q, own_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [RW-1:0] rpt_q, rpt_d;
   logic          live_q, live_d;
   logic          phase_q, phase_d;
   logic [3:0]    plus_q, minus_q;
   logic          stb_p, stb_m;
   logic          held_p, held_m;

   // Held level as it will be after this edge, so same-edge presses count.
   assign held_p = prs[BTN_PLUS]  | (~lvl[BTN_PLUS]  & ~rel[BTN_PLUS]);
   assign held_m = prs[BTN_MINUS] | (~lvl[BTN_MINUS] & ~rel[BTN_MINUS]);

   always_ff @(negedge MCLK or negedge resetSignal) begin
      if (!resetSignal) state_q <= ST_RUN;
      else              state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      own_d   = own_q;
      tmo_d   = tmo_q;
      rpt_d   = rpt_q;
      live_d  = live_q;
      phase_d = phase_q;
      stb_p   = 1'b0;
      stb_m   = 1'b0;
      if (state_q == ST_RUN) begin
         own_d   = OWN_NONE;
         tmo_d   = '0;
         rpt_d   = '0;
         live_d  = 1'b0;
         phase_d = 1'b0;
         if (prs[BTN_MODE]) state_d = ST_SET_HT;
      end else begin
         if (|prs)                                             tmo_d = '0;
         else if (bus.tick && tmo_q != TW'(TIMEOUT_TICKS))     tmo_d = tmo_q + 1'b1;
         if (bus.tick) phase_d = ~phase_q;

         if (prs[BTN_MODE]) begin
            state_d = next_mode(state_q);
            own_d   = OWN_NONE;
            rpt_d   = '0;
            live_d  = 1'b0;
         end else if (held_p && held_m) begin
            own_d  = OWN_NONE;
            rpt_d  = '0;
            live_d = 1'b0;
         end else if (prs[BTN_PLUS]) begin
            own_d  = OWN_PLUS;
            rpt_d  = '0;
            live_d = 1'b0;
            stb_p  = 1'b1;
         end else if (prs[BTN_MINUS]) begin
            own_d  = OWN_MINUS;
            rpt_d  = '0;
            live_d = 1'b0;
            stb_m  = 1'b1;
         end else if ((own_q == OWN_PLUS && !held_p) || (own_q == OWN_MINUS && !held_m)) begin
            own_d  = OWN_NONE;
            rpt_d  = '0;
            live_d = 1'b0;
         end else if (own_q != OWN_NONE && bus.tick) begin
            // First repeat waits the delay, later ones the rate.
            if (int'(rpt_q) + 1 >= (live_q ? REPEAT_RATE_TICKS : REPEAT_DELAY_TICKS)) begin
               rpt_d  = '0;
               live_d = 1'b1;
               stb_p  = (own_q == OWN_PLUS);
               stb_m  = (own_q == OWN_MINUS);
            end else begin
               rpt_d = rpt_q + 1'b1;
            end
         end

         if (!(|prs) && bus.tick && int'(tmo_q) + 1 >= TIMEOUT_TICKS) begin
            state_d = ST_RUN;
            own_d   = OWN_NONE;
            stb_p   = 1'b0;
            stb_m   = 1'b0;
         end
         if (stb_p || stb_m || state_d == ST_RUN) phase_d = 1'b0;
      end
   end

   always_ff @(negedge MCLK or negedge resetSignal) begin
      if (!resetSignal) begin
         own_q   <= OWN_NONE;
         tmo_q   <= '0;
         rpt_q   <= '0;
         live_q  <= 1'b0;
         phase_q <= 1'b0;
         plus_q  <= 4'b1111;
         minus_q <= 4'b1111;
      end else begin
         own_q   <= own_d;
         tmo_q   <= tmo_d;
         rpt_q   <= rpt_d;
         live_q  <= live_d;
         phase_q <= phase_d;
         plus_q  <= stb_p ? ~field_mask(field_of(state_q)) : 4'b1111;
         minus_q <= stb_m ? ~field_mask(field_of(state_q)) : 4'b1111;
      end
   end

   assign bus.stopSignal = (state_q == ST_RUN);
   assign bus.setField   = (state_q == ST_RUN) ? 2'd0 : field_of(state_q);
   assign bus.blinkMask  = (state_q == ST_RUN) ? 4'b0000 :
                           (field_mask(field_of(state_q)) & {4{phase_q}});
   assign bus.plusOut    = plus_q;
   assign bus.minusOut   = minus_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Bench for clock_set_controller: table vectors, randomized cases against a
// strobe-count model, and hand sequences for timeout, blink and reset corners.
module tb_clock_set_controller;
   localparam int DEB  = 16;
   localparam int DLY  = 2;
   localparam int RATE = 1;
   localparam int TMO  = 40;

   logic MCLK = 1'b0;
   logic resetSignal = 1'b0;
   clock_set_if bus();

   clock_set_controller #(
      .DEBOUNCE_CYCLES    (DEB),
      .REPEAT_DELAY_TICKS (DLY),
      .REPEAT_RATE_TICKS  (RATE),
      .TIMEOUT_TICKS      (TMO)
   ) dut (
      .MCLK        (MCLK),
      .resetSignal (resetSignal),
      .bus         (bus)
   );

   always #5 MCLK = ~MCLK;

   int errors = 0;
   int checks = 0;
   int pc [4];
   int mc [4];
   logic [3:0] prev_p = 4'hF, prev_m = 4'hF;

   typedef struct {
      int nmode; int btn; int nticks; int bounce;
      int exp_field; int exp_stop; int exp_pc; int exp_mc;
   } vec_t;
   vec_t tbl [7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Strobe counting and one-cycle width check, sampled on the inactive edge.
   always @(posedge MCLK) begin
      if (resetSignal) begin
         for (int i = 0; i < 4; i++) begin
            if (!bus.plusOut[i]) begin
               pc[i]++;
               checks++;
               if (!prev_p[i]) begin
                  errors++;
                  $display("FAIL strobe_width plus[%0d]: got 2+ low cycles expected 1", i);
               end
            end
            if (!bus.minusOut[i]) begin
               mc[i]++;
               checks++;
               if (!prev_m[i]) begin
                  errors++;
                  $display("FAIL strobe_width minus[%0d]: got 2+ low cycles expected 1", i);
               end
            end
         end
      end
      prev_p <= bus.plusOut;
      prev_m <= bus.minusOut;
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge MCLK);
   endtask

   task automatic clr_cnt;
      for (int i = 0; i < 4; i++) begin
         pc[i] = 0;
         mc[i] = 0;
      end
   endtask

   function automatic int sum4(input int a0, input int a1, input int a2, input int a3);
      return a0 + a1 + a2 + a3;
   endfunction

   task automatic do_reset;
      @(posedge MCLK);
      resetSignal  = 1'b0;
      bus.tick     = 1'b0;
      bus.modeBtn  = 1'b1;
      bus.plusBtn  = 1'b1;
      bus.minusBtn = 1'b1;
      cyc(2);
      resetSignal = 1'b1;
      cyc(2);
   endtask

   task automatic press_mode;
      bus.modeBtn = 1'b0;
      cyc(25);
      bus.modeBtn = 1'b1;
      cyc(25);
   endtask

   task automatic pulse_tick;
      bus.tick = 1'b1;
      cyc(1);
      bus.tick = 1'b0;
      cyc(6);
   endtask

   task automatic set_btn(input int btn, input logic v);
      if (btn == 1 || btn == 3) bus.plusBtn  = v;
      if (btn == 2 || btn == 3) bus.minusBtn = v;
   endtask

   task automatic run_case(input int nmode, input int btn, input int nticks, input int bounce);
      do_reset;
      repeat (nmode) press_mode;
      clr_cnt;
      if (bounce != 0)
         for (int i = 0; i < 5; i++) begin
            set_btn(btn, logic'(i % 2));
            cyc(1);
         end
      set_btn(btn, 1'b0);
      cyc(25);
      repeat (nticks) pulse_tick;
      set_btn(btn, 1'b1);
      cyc(25);
   endtask

   // Reference: one strobe at press, then one at tick DLY and every RATE after.
   function automatic int exp_strobes(input int n);
      if (n < DLY) return 1;
      return 2 + (n - DLY) / RATE;
   endfunction

   initial begin
      int k, b, n, ef, es, ep, em;
      bus.tick = 1'b0;
      bus.modeBtn = 1'b1;
      bus.plusBtn = 1'b1;
      bus.minusBtn = 1'b1;
      clr_cnt;

      tbl[0] = '{3, 1, 3, 1, 1, 0, 3, 0};
      tbl[1] = '{2, 3, 10, 0, 2, 0, 0, 0};
      tbl[2] = '{0, 1, 3, 0, 0, 1, 0, 0};
      tbl[3] = '{4, 2, 1, 0, 0, 0, 0, 1};
      tbl[4] = '{5, 1, 2, 0, 0, 1, 0, 0};
      tbl[5] = '{1, 2, 2, 0, 3, 0, 0, 2};
      tbl[6] = '{2, 1, 0, 1, 2, 0, 1, 0};

      // Reset state held with no activity
      cyc(3);
      resetSignal = 1'b1;
      cyc(50);
      chk("rst_stop", bus.stopSignal, 1);
      chk("rst_plus", bus.plusOut, 4'hF);
      chk("rst_minus", bus.minusOut, 4'hF);
      chk("rst_blink", bus.blinkMask, 0);
      chk("rst_field", bus.setField, 0);

      // Mode walk
      press_mode; chk("mode1_field", bus.setField, 3); chk("mode1_stop", bus.stopSignal, 0);
      press_mode; chk("mode2_field", bus.setField, 2);
      press_mode; chk("mode3_field", bus.setField, 1);
      press_mode; chk("mode4_field", bus.setField, 0); chk("mode4_stop", bus.stopSignal, 0);
      press_mode; chk("mode5_stop", bus.stopSignal, 1); chk("mode5_field", bus.setField, 0);

      foreach (tbl[i]) begin
         run_case(tbl[i].nmode, tbl[i].btn, tbl[i].nticks, tbl[i].bounce);
         chk("tbl_field", bus.setField, tbl[i].exp_field);
         chk("tbl_stop", bus.stopSignal, tbl[i].exp_stop);
         chk("tbl_plus_sel", pc[tbl[i].exp_field], tbl[i].exp_pc);
         chk("tbl_plus_all", sum4(pc[0], pc[1], pc[2], pc[3]), tbl[i].exp_pc);
         chk("tbl_minus_sel", mc[tbl[i].exp_field], tbl[i].exp_mc);
         chk("tbl_minus_all", sum4(mc[0], mc[1], mc[2], mc[3]), tbl[i].exp_mc);
      end

      for (int it = 0; it < 20; it++) begin
         k = $urandom_range(0, 5);
         b = $urandom_range(1, 2);
         n = $urandom_range(0, 5);
         run_case(k, b, n, 0);
         es = (k % 5 == 0) ? 1 : 0;
         ef = (es == 1) ? 0 : 4 - (k % 5);
         ep = (es == 0 && b == 1) ? exp_strobes(n) : 0;
         em = (es == 0 && b == 2) ? exp_strobes(n) : 0;
         chk("rnd_field", bus.setField, ef);
         chk("rnd_stop", bus.stopSignal, es);
         chk("rnd_plus_sel", pc[ef], ep);
         chk("rnd_plus_all", sum4(pc[0], pc[1], pc[2], pc[3]), ep);
         chk("rnd_minus_all", sum4(mc[0], mc[1], mc[2], mc[3]), em);
      end

      // Timeout back to RUN after TMO idle ticks
      do_reset;
      press_mode;
      pulse_tick;
      chk("blink_ht_on", bus.blinkMask, 4'b1000);
      pulse_tick;
      chk("blink_ht_off", bus.blinkMask, 4'b0000);
      repeat (TMO - 3) pulse_tick;
      chk("tmo_before_field", bus.setField, 3);
      chk("tmo_before_stop", bus.stopSignal, 0);
      pulse_tick;
      chk("tmo_stop", bus.stopSignal, 1);
      chk("tmo_blink", bus.blinkMask, 0);
      chk("tmo_field", bus.setField, 0);

      // Strobe clears blink phase
      do_reset;
      repeat (3) press_mode;
      clr_cnt;
      pulse_tick;
      chk("blink_mt_on", bus.blinkMask, 4'b0010);
      bus.plusBtn = 1'b0;
      cyc(25);
      chk("blink_after_strobe", bus.blinkMask, 0);
      bus.plusBtn = 1'b1;
      cyc(25);
      chk("blink_strobe_cnt", pc[1], 1);

      // Mode press while plus held cancels repeat
      do_reset;
      press_mode;
      clr_cnt;
      bus.plusBtn = 1'b0;
      cyc(25);
      press_mode;
      repeat (3) pulse_tick;
      bus.plusBtn = 1'b1;
      cyc(25);
      chk("mh_field", bus.setField, 2);
      chk("mh_ht_cnt", pc[3], 1);
      chk("mh_hu_cnt", pc[2], 0);

      // Reset in the middle of an auto-repeat strobe
      do_reset;
      repeat (4) press_mode;
      clr_cnt;
      bus.plusBtn = 1'b0;
      cyc(25);
      pulse_tick;
      bus.tick = 1'b1;
      cyc(1);
      chk("rr_strobe_low", bus.plusOut, 4'b1110);
      resetSignal = 1'b0;
      #1;
      bus.tick = 1'b0;
      chk("rr_plus_idle", bus.plusOut, 4'hF);
      chk("rr_stop", bus.stopSignal, 1);
      chk("rr_field", bus.setField, 0);
      chk("rr_blink", bus.blinkMask, 0);
      cyc(2);
      resetSignal = 1'b1;
      clr_cnt;
      cyc(30);
      repeat (3) pulse_tick;
      bus.plusBtn = 1'b1;
      cyc(25);
      chk("rr_no_strobe", sum4(pc[0], pc[1], pc[2], pc[3]), 0);
      chk("rr_stop_after", bus.stopSignal, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
